// File: rtl/vc_demux_fifo_pkg.sv
// rtl/vc_demux_fifo_pkg.sv - shared VC routing constants for pop stage, demux and arbiter
package vc_demux_fifo_pkg;

  localparam int VC_SEL_BIT  = 4;
  localparam int DATA_W_DEF  = 6;

  typedef enum logic {
    VC0 = 1'b0,
    VC1 = 1'b1
  } vc_id_t;

  function automatic vc_id_t vc_of(input logic [DATA_W_DEF-1:0] word);
    return vc_id_t'(word[VC_SEL_BIT]);
  endfunction

endpackage

// File: rtl/vc_demux_fifo_vc_fifo.sv
// rtl/vc_demux_fifo_vc_fifo.sv - single VC FIFO with registered read and error pulses
module vc_fifo #(
  parameter int DATA_W    = 6,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  parameter int PTR_W     = $clog2(DEPTH),
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A pop on a full FIFO frees a slot this cycle, so the push is accepted.
  assign do_pop    = pop && (count != '0);
  assign do_push   = push && ((count < CNT_W'(DEPTH)) || do_pop);
  assign overflow  = push && !do_push;
  assign underflow = pop && (count == '0);

  assign empty = (count == '0);
  assign full  = (count >= CNT_W'(AF_THRESH));

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/vc_demux_fifo.sv
// rtl/vc_demux_fifo.sv - steers popped main-FIFO words into two VC FIFOs by class bit
module vc_demux_fifo
  import vc_demux_fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     push,
  input  logic                     vc0_pop,
  input  logic                     vc1_pop,
  output logic                     vc0_full,
  output logic                     vc1_full,
  output logic                     vc0_empty,
  output logic                     vc1_empty,
  output logic [DATA_W-1:0]        vc0_data_out,
  output logic [DATA_W-1:0]        vc1_data_out,
  output logic [$clog2(DEPTH):0]   vc0_count,
  output logic [$clog2(DEPTH):0]   vc1_count,
  output logic                     error_out
);

  vc_id_t sel;
  logic   push0;
  logic   push1;
  logic   ovf0;
  logic   ovf1;
  logic   udf0;
  logic   udf1;

  assign sel   = vc_id_t'(data_in[VC_SEL_BIT]);
  assign push0 = push && (sel == VC0);
  assign push1 = push && (sel == VC1);

  vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) u_vc0 (
    .clk       (clk),
    .reset_L   (reset_L),
    .push      (push0),
    .wr_data   (data_in),
    .pop       (vc0_pop),
    .rd_data   (vc0_data_out),
    .count     (vc0_count),
    .full      (vc0_full),
    .empty     (vc0_empty),
    .overflow  (ovf0),
    .underflow (udf0)
  );

  vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) u_vc1 (
    .clk       (clk),
    .reset_L   (reset_L),
    .push      (push1),
    .wr_data   (data_in),
    .pop       (vc1_pop),
    .rd_data   (vc1_data_out),
    .count     (vc1_count),
    .full      (vc1_full),
    .empty     (vc1_empty),
    .overflow  (ovf1),
    .underflow (udf1)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      error_out <= 1'b0;
    end else if (ovf0 || ovf1 || udf0 || udf1) begin
      error_out <= 1'b1;
    end
  end

endmodule

// File: doc/vc_demux_fifo.md
Name: vc_demux_fifo

Overview:
- Downstream neighbour of the main-FIFO pop stage.
- Takes each word popped from the main FIFO and steers it into one of two virtual-channel FIFOs (VC0, VC1) using the class bit in the word.
- Returns per-VC full/almost-full status to the pop stage, which gates its pop on it.
- Provides per-VC read ports for the downstream arbiter.

Parameters:
- DATA_W, 6, word width; bit 4 is the VC select, all bits are stored unchanged.
- DEPTH, 4, entries per VC FIFO; must be a power of 2 and at least 2.
- AF_THRESH, 3, occupancy at or above which vcN_full asserts toward the pop stage; must satisfy 1 <= AF_THRESH <= DEPTH.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- data_in  in  DATA_W  word popped from the main FIFO.
- push  in  1  data_in valid this cycle; this is the pop strobe of the upstream stage.
- vc0_pop  in  1  read request, VC0.
- vc1_pop  in  1  read request, VC1.
- vc0_full  out  1  VC0 occupancy >= AF_THRESH, used as back-pressure.
- vc1_full  out  1  VC1 occupancy >= AF_THRESH.
- vc0_empty  out  1  VC0 occupancy == 0.
- vc1_empty  out  1  VC1 occupancy == 0.
- vc0_data_out  out  DATA_W  registered read data, VC0.
- vc1_data_out  out  DATA_W  registered read data, VC1.
- vc0_count  out  log2(DEPTH)+1  VC0 occupancy.
- vc1_count  out  log2(DEPTH)+1  VC1 occupancy.
- error_out  out  1  sticky flag: overflow or underflow on either VC.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - All pointers and counts go to 0.
  - vcN_empty=1, vcN_full=0.
  - vcN_data_out=0, error_out=0.
  - Memory contents are don't-care.
  - Assertion mid-operation discards all stored words immediately.
  - Reset release is synchronous to clk.
- Routing: when push=1, the target is VC0 if data_in[4]=0 and VC1 if data_in[4]=1. The non-target VC sees no write.
- Write:
  - Accepted when the target count < DEPTH.
  - On accept, mem[wr_ptr] <= data_in and wr_ptr advances.
  - Occupancy becomes visible the next cycle (1-cycle latency to count, empty and full).
- Overflow:
  - A push to a VC with count == DEPTH is dropped.
  - Pointers and count are unchanged; error_out <= 1.
- Read:
  - When vcN_pop=1 and count > 0, vcN_data_out <= mem[rd_ptr] on that edge and rd_ptr advances.
  - vcN_data_out holds its value when no pop occurs.
- Underflow:
  - vcN_pop with count == 0 is ignored; data_out holds; error_out <= 1.
- Simultaneous push and pop on the same VC:
  - Both proceed; count is unchanged.
  - When count == DEPTH, the pop frees a slot in the same cycle, so the push is accepted and error_out does not set.
  - When count == 0, the pop is an underflow (no bypass) and the push is accepted.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH and is derived from its own register, not from pointer difference.
- vcN_full and vcN_empty are combinational decodes of the count register, so they are glitch-free relative to clk.
- AF_THRESH below DEPTH leaves slack for the upstream stage's 1-cycle reaction latency.
- error_out stays at 1 until reset.

Decomposition:
- Shared package: VC_SEL_BIT=4, DATA_W default, and the vc_id encoding (VC0=0, VC1=1). The same package serves the pop stage and the arbiter.
- One sub-module, vc_fifo (DATA_W, DEPTH, AF_THRESH), instantiated twice.
  - It holds the memory, pointers, count, full/empty decode, and per-FIFO overflow/underflow pulses.
  - The top level does the demux of push, and ORs the error pulses into the sticky error_out.

Test Plan:
- Reset, then push 6'b00_0001 -> next cycle vc0_count=1, vc0_empty=0, vc1_empty=1. Then vc0_pop -> vc0_data_out=6'h01, vc0_count=0.
- Push 6'b01_0100 then 6'b00_0101 -> vc1_count=1 and vc0_count=1. Pop both -> vc1_data_out=6'h14, vc0_data_out=6'h05.
- Push 3 words to VC0 -> vc0_full=1 at count 3. A 4th push -> count 4, error_out stays 0. A 5th push -> dropped, count stays 4, error_out=1.
- Fill VC1 to 4, then push and pop VC1 in the same cycle -> count stays 4, error_out=0. Data order after draining is preserved FIFO-wise across pointer wrap.
- vc0_pop with VC0 empty -> vc0_data_out unchanged, error_out=1. Assert reset_L=0 mid-stream with 2 words stored -> immediate counts=0, empty=1, error_out=0.
